// File: rtl/l2req_arbiter_pkg.sv
// Shared types and constants for the per-core L2 request arbiter.
package l2req_arbiter_pkg;

  localparam int unsigned NUM_L2_REQUESTERS = 3;
  localparam int unsigned REQ_ICACHE        = 0;
  localparam int unsigned REQ_DCACHE        = 1;
  localparam int unsigned REQ_STBUF         = 2;

  localparam int unsigned CORE_W = 4;
  localparam int unsigned OP_W   = 2;
  localparam int unsigned ADDR_W = 32;

  typedef struct packed {
    logic              valid;
    logic [CORE_W-1:0] core;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
  } l2req_packet_t;

  // Explicit modulo wrap; idx is never more than 2*n-1 here.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the slot after the last winner.
module rr_arbiter
  import l2req_arbiter_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] request,
  input  logic         update_lru,
  output logic [N-1:0] grant_oh
);

  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_next_ptr;
  logic [PTR_W-1:0] w_cand;
  logic             w_found;

  always_comb begin
    grant_oh   = '0;
    w_next_ptr = r_ptr;
    w_cand     = '0;
    w_found    = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_cand = PTR_W'(rr_wrap(32'(r_ptr) + k, N));
      if (!w_found && request[w_cand]) begin
        w_found          = 1'b1;
        grant_oh[w_cand] = 1'b1;
        w_next_ptr       = w_cand;
      end
    end
  end

  // Reset to N-1 so index 0 is the first winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= PTR_W'(N - 1);
    end else if (update_lru) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/l2req_arbiter.sv
// Shares one core's L2 request port between icache, dcache and store buffer
// through a round-robin grant feeding a single output holding register.
module l2req_arbiter
  import l2req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUESTERS = NUM_L2_REQUESTERS,
  parameter int unsigned CORE_ID        = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] req_valid,
  input  l2req_packet_t             req_packet [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] req_ack,
  input  logic                      l2req_ready,
  output l2req_packet_t             l2req_packet,
  output logic                      pc_event_l2req_stall
);

  l2req_packet_t               r_pkt;
  l2req_packet_t               w_sel;
  logic                        w_can_load;
  logic                        w_update;
  logic [NUM_REQUESTERS-1:0]   w_grant_oh;

  assign w_can_load = !r_pkt.valid || l2req_ready;
  assign w_update   = w_can_load && (|req_valid);

  rr_arbiter #(.N(NUM_REQUESTERS)) u_rr (
    .clk        (clk),
    .reset_n    (reset_n),
    .request    (req_valid),
    .update_lru (w_update),
    .grant_oh   (w_grant_oh)
  );

  assign req_ack = (w_can_load && reset_n) ? w_grant_oh : '0;

  // One-hot grant mux; valid is forced because occupancy is ours, not the requester's.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_REQUESTERS; i++) begin
      if (req_ack[i]) begin
        w_sel = req_packet[i];
      end
    end
    w_sel.valid = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt <= '0;
    end else if (|req_ack) begin
      r_pkt <= w_sel;
    end else if (l2req_ready && r_pkt.valid) begin
      r_pkt.valid <= 1'b0;
    end
  end

  assign l2req_packet         = r_pkt;
  assign pc_event_l2req_stall = r_pkt.valid && !l2req_ready;

`ifndef SYNTHESIS
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(req_ack));
  a_hold_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (r_pkt.valid && !l2req_ready) |=> $stable(r_pkt));
  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_core_chk
    a_core: assert property (@(posedge clk) disable iff (!reset_n)
      req_valid[gi] |-> (req_packet[gi].core == CORE_W'(CORE_ID)));
  end
`endif

endmodule

// File: tb/tb_l2req_arbiter.sv
// Directed bench for l2req_arbiter with a scoreboard of expected L2 packets.
module tb_l2req_arbiter;
  import l2req_arbiter_pkg::*;

  localparam int unsigned N = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req_valid;
  l2req_packet_t req_packet [N];
  logic [N-1:0]  req_ack;
  logic          l2req_ready;
  l2req_packet_t l2req_packet;
  logic          pc_event_l2req_stall;

  int            checks   = 0;
  int            failures = 0;
  l2req_packet_t exp_q [$];
  int unsigned   seq [N];
  l2req_packet_t hold;

  always #5 clk = ~clk;

  l2req_arbiter #(.NUM_REQUESTERS(N), .CORE_ID(0)) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .req_valid            (req_valid),
    .req_packet           (req_packet),
    .req_ack              (req_ack),
    .l2req_ready          (l2req_ready),
    .l2req_packet         (l2req_packet),
    .pc_event_l2req_stall (pc_event_l2req_stall)
  );

  function automatic l2req_packet_t mk_pkt(input int unsigned i, input int unsigned s);
    l2req_packet_t p;
    p      = '0;
    p.core = CORE_W'(0);
    p.op   = OP_W'(i);
    p.addr = {8'(i), 24'(s)};
    return p;
  endfunction

  task automatic check_bits(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_pkts();
    for (int i = 0; i < int'(N); i++) req_packet[i] = mk_pkt(i, seq[i]);
  endtask

  // One cycle: drive at negedge, check ack/occupancy/stall, record expected captures.
  task automatic cyc(input logic [2:0] v, input logic rdy, input logic [2:0] ea, input logic eov);
    l2req_packet_t p;
    @(negedge clk);
    req_valid   = v;
    l2req_ready = rdy;
    drive_pkts();
    #1;
    check_bits("req_ack", 64'(req_ack), 64'(ea));
    check_bits("out_valid", 64'(l2req_packet.valid), 64'(eov));
    check_bits("stall", 64'(pc_event_l2req_stall), 64'(eov && !rdy));
    for (int i = 0; i < int'(N); i++) begin
      if (ea[i]) begin
        p       = mk_pkt(i, seq[i]);
        p.valid = 1'b1;
        exp_q.push_back(p);
        seq[i]++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    req_valid   = '0;
    l2req_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    check_bits(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every accepted L2 transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    l2req_packet_t e;
    #2;
    if (reset_n === 1'b1 && l2req_packet.valid === 1'b1 && l2req_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pkt actual=%0h required=none t=%0t", l2req_packet, $time);
      end else begin
        e = exp_q.pop_front();
        check_bits("l2req_packet", 64'(l2req_packet), 64'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(N); i++) seq[i] = 0;
    reset_n     = 1'b0;
    req_valid   = 3'b111;
    l2req_ready = 1'b0;
    drive_pkts();
    #2;
    check_bits("rst_packet", 64'(l2req_packet), 64'd0);
    check_bits("rst_ack", 64'(req_ack), 64'd0);
    check_bits("rst_stall", 64'(pc_event_l2req_stall), 64'd0);
    req_valid = '0;
    @(negedge clk);
    #3 reset_n = 1'b1;

    // Single dcache request, one-cycle latency then bubble.
    cyc(3'b010, 1'b1, 3'b010, 1'b0);
    cyc(3'b000, 1'b1, 3'b000, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b0);
    check_drained("t1_drain");

    // All valid from reset: 0,1,2,0,1,2 back-to-back.
    do_reset();
    cyc(3'b111, 1'b1, 3'b001, 1'b0);
    cyc(3'b111, 1'b1, 3'b010, 1'b1);
    cyc(3'b111, 1'b1, 3'b100, 1'b1);
    cyc(3'b111, 1'b1, 3'b001, 1'b1);
    cyc(3'b111, 1'b1, 3'b010, 1'b1);
    cyc(3'b111, 1'b1, 3'b100, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b0);
    check_drained("t2_drain");

    // Backpressure: first packet held stable for 5 cycles, then replaced on ready.
    do_reset();
    hold       = mk_pkt(0, seq[0]);
    hold.valid = 1'b1;
    cyc(3'b111, 1'b0, 3'b001, 1'b0);
    for (int c = 0; c < 5; c++) begin
      cyc(3'b111, 1'b0, 3'b000, 1'b1);
      check_bits("hold_stable", 64'(l2req_packet), 64'(hold));
    end
    cyc(3'b111, 1'b1, 3'b010, 1'b1);
    cyc(3'b101, 1'b1, 3'b100, 1'b1);
    cyc(3'b001, 1'b1, 3'b001, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b0);
    check_drained("t3_drain");

    // Fairness under churn: 0 always requesting, 1 and 2 one request each.
    do_reset();
    cyc(3'b001, 1'b1, 3'b001, 1'b0);
    cyc(3'b111, 1'b1, 3'b010, 1'b1);
    cyc(3'b101, 1'b1, 3'b100, 1'b1);
    cyc(3'b001, 1'b1, 3'b001, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b0);
    check_drained("t4_drain");

    // Wrap-around: ptr at 2 with only requester 2 pending; ptr stays 2.
    do_reset();
    cyc(3'b100, 1'b1, 3'b100, 1'b0);
    cyc(3'b100, 1'b1, 3'b100, 1'b1);
    cyc(3'b011, 1'b1, 3'b001, 1'b1);
    cyc(3'b010, 1'b1, 3'b010, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b0);
    check_drained("t5_drain");

    // Async reset mid-stall, between clock edges.
    do_reset();
    cyc(3'b111, 1'b0, 3'b001, 1'b0);
    cyc(3'b111, 1'b0, 3'b000, 1'b1);
    cyc(3'b111, 1'b0, 3'b000, 1'b1);
    #2;
    reset_n   = 1'b0;
    req_valid = 3'b111;
    exp_q.delete();
    #1;
    check_bits("async_rst_valid", 64'(l2req_packet.valid), 64'd0);
    check_bits("async_rst_ack", 64'(req_ack), 64'd0);
    check_bits("async_rst_stall", 64'(pc_event_l2req_stall), 64'd0);
    req_valid = '0;
    @(negedge clk);
    #3 reset_n = 1'b1;
    cyc(3'b111, 1'b1, 3'b001, 1'b0);
    cyc(3'b000, 1'b1, 3'b000, 1'b1);
    cyc(3'b000, 1'b1, 3'b000, 1'b0);
    check_drained("t6_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
